macc_dot_sequencer: RTL
=======================

Name: macc_dot_sequencer

Overview:
Sequences the shared 16-bit multiply-accumulate datapath through one dot product per job, over two single-port ROM/RAM banks (coefficients and samples).
- Accepts a job (two base addresses, a length) over a valid/ready handshake.
- Clears the MAC, streams address pairs, gates operands into the MAC and waits out the pipeline.
- Presents the final accumulator over a second valid/ready handshake.
- Sits between the NCO control registers and the MAC/memories.

Parameters:
DATA_W, 16, operand width (matches MAC a/b)
ACC_W, 32, accumulator/result width
ADDR_W, 8, memory address width; max job length 2^ADDR_W
MEM_LAT, 1, memory read latency in cycles (address to rdata)
MAC_LAT, 2, cycles from operand at MAC input to its contribution visible on mac_acc

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
start_valid  in  1  job request
start_ready  out  1  job accepted when start_valid & start_ready
start_len  in  ADDR_W+1  number of products; legal 1..2^ADDR_W
coef_base  in  ADDR_W  first coefficient address
samp_base  in  ADDR_W  first sample address
rd_en  out  1  memory read strobe, both banks
coef_addr  out  ADDR_W  coefficient read address
samp_addr  out  ADDR_W  sample read address
coef_rdata  in  DATA_W  coefficient data, MEM_LAT after address
samp_rdata  in  DATA_W  sample data, MEM_LAT after address
mac_clr  out  1  drives MAC synchronous clear
mac_a  out  DATA_W  MAC operand a
mac_b  out  DATA_W  MAC operand b
mac_acc  in  ACC_W  MAC accumulator
res_valid  out  1  result available
res_ready  in  1  result consumed when res_valid & res_ready
res_data  out  ACC_W  captured dot product, unsigned, mod 2^ACC_W
len_err  out  1  qualifies res_valid; job length illegal
busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (ports clk, rst_n).
- Reset values: state IDLE; start_ready 1; all other outputs 0; internal counters 0.
- States:
  - IDLE: start_ready=1. On accept, latch len/bases.
    - Legal len -> CLEAR.
    - len==0 or len>2^ADDR_W -> DONE with res_data=0, len_err=1.
  - CLEAR (1 cycle): mac_clr=1, registered. The MAC clears acc and its input regs at the exiting edge.
  - ISSUE (exactly len cycles): rd_en=1, coef_addr=coef_base+idx, samp_addr=samp_base+idx. idx runs 0..len-1; addresses wrap mod 2^ADDR_W. Exit after idx==len-1.
  - DRAIN (exactly MEM_LAT+MAC_LAT cycles): rd_en=0. On the exit edge, res_data<=mac_acc and len_err<=0.
  - DONE: res_valid=1; res_data and len_err held stable. On res_valid&res_ready -> IDLE.
- Operand gating: a MEM_LAT-deep shift register delays rd_en to give op_vld.
  - mac_a = op_vld ? coef_rdata : 0; mac_b = op_vld ? samp_rdata : 0.
  - Outside valid slots the MAC therefore accumulates 0. This is required because the MAC accumulates every cycle.
- Latency (defaults): res_valid rises len+4 edges after the start-accepting edge (1 CLEAR + len ISSUE + 3 DRAIN). Illegal len: res_valid 1 edge after accept.
- Handshakes:
  - start_ready is high only in IDLE.
  - A start offered during a DONE handshake cycle is accepted no earlier than the next cycle.
  - res_valid, once high, stays high and data stays stable until accepted.
- Arithmetic: unsigned; overflow wraps silently mod 2^ACC_W (MAC behaviour, not corrected).
- Reset mid-job: async return to IDLE, outputs to reset values, job discarded. The next job's CLEAR removes stale MAC state.
- start_len and base inputs are ignored except on the accepting edge.

Decomposition:
- Shared package/header: state encoding (IDLE, CLEAR, ISSUE, DRAIN, DONE) and DRAIN_CYC = MEM_LAT+MAC_LAT.
- One sub-module, macc_vld_delay: a parameterised MEM_LAT-stage 1-bit shift register with async reset, producing op_vld.

Test Plan:
1. len=4, coef[0..3]={1,2,3,4}, samp[0..3]={5,6,7,8}, bases 0 -> res_data=70, len_err=0, res_valid exactly 8 edges after accept; mac_a/mac_b zero outside the 4 op_vld cycles.
2. samp_base=254, coef_base=0, len=4 -> samp_addr sequence 254,255,0,1; result matches the model.
3. len=256, all data 0xFFFF -> res_data=0xFE000100 (wrapped).
4. len=0, and separately len=257 -> no rd_en and no mac_clr; res_valid next cycle with len_err=1, res_data=0.
5. res_ready held low 10 cycles after res_valid, with start_valid held high -> res_data stable, start_ready=0; accept on the cycle after the res handshake.
6. rst_n pulsed low mid-ISSUE -> all outputs 0 immediately. A following len=2 job {3,4}·{10,20} gives 110 with no residue from the aborted job.

Source files
------------

// File: rtl/macc_dot_sequencer_pkg.sv
// Shared definitions for the dot-product sequencer: FSM state encoding and
// the drain length that covers memory plus MAC pipeline latency.
package macc_dot_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_ISSUE = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam int DEF_MEM_LAT = 1;
    localparam int DEF_MAC_LAT = 2;
    localparam int DRAIN_CYC   = DEF_MEM_LAT + DEF_MAC_LAT;

    // Cycles from the last issued address until its product is on mac_acc.
    function automatic int drain_cycles(input int mem_lat, input int mac_lat);
        return mem_lat + mac_lat;
    endfunction

endpackage

// File: rtl/macc_dot_sequencer_vld_delay.sv
// macc_vld_delay: STAGES-deep 1-bit shift register. Delays the read strobe so
// that the operand-valid flag lines up with the memory read data.
module macc_vld_delay #(
    parameter int STAGES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_vld,
    output logic out_vld
);

    generate
        if (STAGES == 0) begin : g_bypass
            assign out_vld = in_vld;
        end else begin : g_shift
            logic [STAGES-1:0] stage_q;
            logic [STAGES-1:0] stage_d;

            // Shift one position per cycle, new strobe enters at bit 0.
            always_comb begin
                stage_d    = stage_q << 1;
                stage_d[0] = in_vld;
            end

            // Stage registers, cleared by reset so no stale valid survives an abort.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stage_q <= '0;
                end else begin
                    stage_q <= stage_d;
                end
            end

            assign out_vld = stage_q[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/macc_dot_sequencer.sv
// Dot-product sequencer: accepts a job (two base addresses and a length),
// clears the shared MAC, streams address pairs to the coefficient and sample
// banks, gates the returned operands into the MAC and, after the pipeline has
// drained, presents the accumulator as the result.
module macc_dot_sequencer
    import macc_dot_sequencer_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ACC_W   = 32,
    parameter int ADDR_W  = 8,
    parameter int MEM_LAT = 1,
    parameter int MAC_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic [ADDR_W:0]   start_len,
    input  logic [ADDR_W-1:0] coef_base,
    input  logic [ADDR_W-1:0] samp_base,
    output logic              rd_en,
    output logic [ADDR_W-1:0] coef_addr,
    output logic [ADDR_W-1:0] samp_addr,
    input  logic [DATA_W-1:0] coef_rdata,
    input  logic [DATA_W-1:0] samp_rdata,
    output logic              mac_clr,
    output logic [DATA_W-1:0] mac_a,
    output logic [DATA_W-1:0] mac_b,
    input  logic [ACC_W-1:0]  mac_acc,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_data,
    output logic              len_err,
    output logic              busy
);

    localparam int DRAIN_LEN = drain_cycles(MEM_LAT, MAC_LAT);
    localparam int CNT_W     = (DRAIN_LEN > 1) ? $clog2(DRAIN_LEN) : 1;
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_LEN - 1);
    // Largest legal length is 2^ADDR_W, i.e. only the MSB of start_len set.
    localparam logic [ADDR_W:0]  MAX_LEN    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]  LEN_ONE    = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    state_e              state_q,     state_d;
    logic [ADDR_W-1:0]   len_m1_q,    len_m1_d;
    logic [ADDR_W-1:0]   idx_q,       idx_d;
    logic [CNT_W-1:0]    drain_q,     drain_d;
    logic [ADDR_W-1:0]   coef_base_q, coef_base_d;
    logic [ADDR_W-1:0]   samp_base_q, samp_base_d;
    logic [ADDR_W-1:0]   coef_addr_q, coef_addr_d;
    logic [ADDR_W-1:0]   samp_addr_q, samp_addr_d;
    logic                rd_en_q,     rd_en_d;
    logic                mac_clr_q,   mac_clr_d;
    logic [ACC_W-1:0]    res_data_q,  res_data_d;
    logic                len_err_q,   len_err_d;
    logic                op_vld;
    logic                len_legal;

    assign len_legal = (start_len != '0) && (start_len <= MAX_LEN);

    // Next-state and registered-output computation for the job sequencer.
    always_comb begin
        state_d     = state_q;
        len_m1_d    = len_m1_q;
        idx_d       = idx_q;
        drain_d     = drain_q;
        coef_base_d = coef_base_q;
        samp_base_d = samp_base_q;
        coef_addr_d = coef_addr_q;
        samp_addr_d = samp_addr_q;
        rd_en_d     = rd_en_q;
        mac_clr_d   = 1'b0;
        res_data_d  = res_data_q;
        len_err_d   = len_err_q;

        case (state_q)
            ST_IDLE: begin
                // start_ready is high here, so start_valid alone accepts.
                if (start_valid) begin
                    if (len_legal) begin
                        state_d     = ST_CLEAR;
                        mac_clr_d   = 1'b1;
                        len_m1_d    = ADDR_W'(start_len - LEN_ONE);
                        coef_base_d = coef_base;
                        samp_base_d = samp_base;
                    end else begin
                        state_d    = ST_DONE;
                        res_data_d = '0;
                        len_err_d  = 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                state_d     = ST_ISSUE;
                rd_en_d     = 1'b1;
                idx_d       = '0;
                coef_addr_d = coef_base_q;
                samp_addr_d = samp_base_q;
            end
            ST_ISSUE: begin
                if (idx_q == len_m1_q) begin
                    state_d = ST_DRAIN;
                    rd_en_d = 1'b0;
                    drain_d = '0;
                end else begin
                    // Address arithmetic wraps naturally at 2^ADDR_W.
                    idx_d       = idx_q + ADDR_ONE;
                    coef_addr_d = coef_addr_q + ADDR_ONE;
                    samp_addr_d = samp_addr_q + ADDR_ONE;
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d    = ST_DONE;
                    res_data_d = mac_acc;
                    len_err_d  = 1'b0;
                end else begin
                    drain_d = drain_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any job in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            len_m1_q    <= '0;
            idx_q       <= '0;
            drain_q     <= '0;
            coef_base_q <= '0;
            samp_base_q <= '0;
            coef_addr_q <= '0;
            samp_addr_q <= '0;
            rd_en_q     <= 1'b0;
            mac_clr_q   <= 1'b0;
            res_data_q  <= '0;
            len_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_m1_q    <= len_m1_d;
            idx_q       <= idx_d;
            drain_q     <= drain_d;
            coef_base_q <= coef_base_d;
            samp_base_q <= samp_base_d;
            coef_addr_q <= coef_addr_d;
            samp_addr_q <= samp_addr_d;
            rd_en_q     <= rd_en_d;
            mac_clr_q   <= mac_clr_d;
            res_data_q  <= res_data_d;
            len_err_q   <= len_err_d;
        end
    end

    // Operand-valid is the read strobe delayed by the memory latency.
    macc_vld_delay #(
        .STAGES (MEM_LAT)
    ) u_vld_delay (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (rd_en_q),
        .out_vld (op_vld)
    );

    // The MAC accumulates every cycle, so feed it zeros outside valid slots.
    assign mac_a = op_vld ? coef_rdata : '0;
    assign mac_b = op_vld ? samp_rdata : '0;

    assign start_ready = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign res_valid   = (state_q == ST_DONE);
    assign rd_en       = rd_en_q;
    assign coef_addr   = coef_addr_q;
    assign samp_addr   = samp_addr_q;
    assign mac_clr     = mac_clr_q;
    assign res_data    = res_data_q;
    assign len_err     = len_err_q;

endmodule
